// File: rtl/fa1b_pkg.sv
// -----------------------------------------------------------------------------
// fa1b_pkg
//   Shared constants and the arithmetic reference model for the fa1b full-adder
//   carry-chain cell.
//
//   FA1B_W       operand width (one bit per cell)
//   FA1B_RES_W   width of the {carry, sum} result
//   FA1B_RST_VAL reset value of every register in the cell
//   fa1b_model() arithmetic A + B + Cin, zero-extended to FA1B_RES_W bits
// -----------------------------------------------------------------------------
package fa1b_pkg;

   localparam int unsigned FA1B_W       = 1;
   localparam int unsigned FA1B_RES_W   = 2;
   localparam logic        FA1B_RST_VAL = 1'b0;

   // Operands are widened before the add so the carry lands in bit 1 instead of
   // being truncated away by the 1-bit context of the operands.
   function automatic logic [FA1B_RES_W-1:0] fa1b_model(
      input logic [FA1B_W-1:0] a,
      input logic [FA1B_W-1:0] b,
      input logic [FA1B_W-1:0] c
   );
      return FA1B_RES_W'(a) + FA1B_RES_W'(b) + FA1B_RES_W'(c);
   endfunction

endpackage : fa1b_pkg

// File: rtl/ha1b.sv
// -----------------------------------------------------------------------------
// ha1b
//   Half adder; two of these plus an OR gate form the fa1b full adder.
//
//   a, b  in   operand bits
//   s     out  sum bit,   a ^ b
//   c     out  carry bit, a & b
// -----------------------------------------------------------------------------
module ha1b (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule : ha1b

// File: rtl/fa1b.sv
// -----------------------------------------------------------------------------
// fa1b
//   Single-bit full adder used as the carry-chain cell of the datapath ALU.
//   Sum/Cout are purely combinational (valid even while in reset); Sum_q/Cout_q
//   are a one-cycle registered copy for pipelined consumers.
//
//   Optional feature, macro FA1B_SELF_CHECK_EN:
//     defined   - the registered result is compared each cycle with a registered
//                 arithmetic model of A + B + Cin; a mismatch sets the sticky
//                 chk_err flag, which only reset clears.
//     undefined - no checker logic; chk_err is tied to 0.
//
//   clk      in   rising-edge clock for the registered copy and checker
//   rst_n    in   asynchronous active-low reset
//   A, B     in   addend bits
//   Cin      in   carry in
//   Sum      out  combinational sum,   A ^ B ^ Cin
//   Cout     out  combinational carry, (A & B) | (Cin & (A ^ B))
//   Sum_q    out  Sum registered on clk
//   Cout_q   out  Cout registered on clk
//   chk_err  out  sticky self-check mismatch flag
// -----------------------------------------------------------------------------
module fa1b
   import fa1b_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout,
   output logic Sum_q,
   output logic Cout_q,
   output logic chk_err
);

   logic p;   // propagate, A ^ B
   logic g0;  // generate from the operands
   logic g1;  // generate from propagate and carry in

   ha1b u_ha0 (
      .a (A),
      .b (B),
      .s (p),
      .c (g0)
   );

   ha1b u_ha1 (
      .a (p),
      .b (Cin),
      .s (Sum),
      .c (g1)
   );

   assign Cout = g0 | g1;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sum_q  <= FA1B_RST_VAL;
         Cout_q <= FA1B_RST_VAL;
      end else begin
         Sum_q  <= Sum;
         Cout_q <= Cout;
      end
   end

`ifdef FA1B_SELF_CHECK_EN
   // The model is registered on the same edge as Sum_q/Cout_q, so both sides of
   // the compare always describe the same input sample. chk_valid suppresses the
   // compare on the first edge after reset, when neither side holds a real
   // sample yet.
   logic [FA1B_RES_W-1:0] model_q;
   logic                  chk_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q   <= '0;
         chk_valid <= 1'b0;
         chk_err   <= FA1B_RST_VAL;
      end else begin
         model_q   <= fa1b_model(A, B, Cin);
         chk_valid <= 1'b1;
         if (chk_valid && ({Cout_q, Sum_q} != model_q)) begin
            chk_err <= 1'b1;
         end
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule : fa1b

// File: tb/tb_fa1b.sv
// -----------------------------------------------------------------------------
// tb_fa1b
//   Self-checking bench for fa1b: table of {A,B,Cin} codes with hand-computed
//   {Cout,Sum}, followed by hand-written registered-path, reset and (when
//   FA1B_SELF_CHECK_EN is defined) checker sequences.
// -----------------------------------------------------------------------------
module tb_fa1b;

   typedef struct {
      string      name;
      logic [2:0] abc;   // {A, B, Cin}
      logic [1:0] cs;    // required {Cout, Sum}
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic A, B, Cin;
   logic Sum, Cout, Sum_q, Cout_q, chk_err;

   int n_checks = 0;
   int n_errors = 0;

   fa1b dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .Cin     (Cin),
      .Sum     (Sum),
      .Cout    (Cout),
      .Sum_q   (Sum_q),
      .Cout_q  (Cout_q),
      .chk_err (chk_err)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic apply(input logic [2:0] abc);
      {A, B, Cin} = abc;
   endtask

   vec_t vecs[23];

   initial begin
      // Gray-code walk forward, then back to 000.
      vecs[0]  = '{"gray 000", 3'b000, 2'b00};
      vecs[1]  = '{"gray 001", 3'b001, 2'b01};
      vecs[2]  = '{"gray 011", 3'b011, 2'b10};
      vecs[3]  = '{"gray 010", 3'b010, 2'b01};
      vecs[4]  = '{"gray 110", 3'b110, 2'b10};
      vecs[5]  = '{"gray 111", 3'b111, 2'b11};
      vecs[6]  = '{"gray 101", 3'b101, 2'b10};
      vecs[7]  = '{"gray 100", 3'b100, 2'b01};
      vecs[8]  = '{"gray back 101", 3'b101, 2'b10};
      vecs[9]  = '{"gray back 111", 3'b111, 2'b11};
      vecs[10] = '{"gray back 110", 3'b110, 2'b10};
      vecs[11] = '{"gray back 010", 3'b010, 2'b01};
      vecs[12] = '{"gray back 011", 3'b011, 2'b10};
      vecs[13] = '{"gray back 001", 3'b001, 2'b01};
      vecs[14] = '{"gray back 000", 3'b000, 2'b00};
      // Exhaustive sweep 0..7.
      vecs[15] = '{"sweep 000", 3'b000, 2'b00};
      vecs[16] = '{"sweep 001", 3'b001, 2'b01};
      vecs[17] = '{"sweep 010", 3'b010, 2'b01};
      vecs[18] = '{"sweep 011", 3'b011, 2'b10};
      vecs[19] = '{"sweep 100", 3'b100, 2'b01};
      vecs[20] = '{"sweep 101", 3'b101, 2'b10};
      vecs[21] = '{"sweep 110", 3'b110, 2'b10};
      vecs[22] = '{"sweep 111", 3'b111, 2'b11};

      // Reset state; combinational path must work while in reset.
      rst_n = 1'b0;
      apply(3'b111);
      #10;
      check("reset q", {Cout_q, Sum_q}, 2'b00);
      check("reset chk_err", {1'b0, chk_err}, 2'b00);
      check("comb in reset", {Cout, Sum}, 2'b11);

      @(negedge clk);
      rst_n = 1'b1;

      // Combinational table: one step every 10 ns.
      for (int i = 0; i < 23; i++) begin
         apply(vecs[i].abc);
         #10;
         check(vecs[i].name, {Cout, Sum}, vecs[i].cs);
      end

      // Registered path.
      @(negedge clk);
      apply(3'b110);
      @(posedge clk);
      #1;
      check("reg 110", {Cout_q, Sum_q}, 2'b10);
      @(negedge clk);
      apply(3'b001);
      @(posedge clk);
      #1;
      check("reg 001", {Cout_q, Sum_q}, 2'b01);

      // Asynchronous reset mid-cycle with inputs at 111.
      @(negedge clk);
      apply(3'b111);
      @(posedge clk);
      #1;
      check("reg 111 pre-reset", {Cout_q, Sum_q}, 2'b11);
      #3;
      rst_n = 1'b0;
      #1;
      check("async reset q", {Cout_q, Sum_q}, 2'b00);
      check("async reset comb", {Cout, Sum}, 2'b11);
      check("async reset chk_err", {1'b0, chk_err}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first edge after reset", {Cout_q, Sum_q}, 2'b11);

      // Registered sweep: chk_err must stay clear for correct results.
      for (int i = 15; i < 23; i++) begin
         @(negedge clk);
         apply(vecs[i].abc);
         @(posedge clk);
         #1;
         check({"reg ", vecs[i].name}, {Cout_q, Sum_q}, vecs[i].cs);
      end
      @(posedge clk);
      #1;
      check("chk_err after sweep", {1'b0, chk_err}, 2'b00);

`ifdef FA1B_SELF_CHECK_EN
      // Inject a Cout_q mismatch: inputs held at 000, Cout_q forced to 1.
      @(negedge clk);
      apply(3'b000);
      @(posedge clk);
      @(negedge clk);
      force dut.Cout_q = 1'b1;
      @(posedge clk);
      @(negedge clk);
      release dut.Cout_q;
      check("chk_err set by injection", {1'b0, chk_err}, 2'b01);
      repeat (3) @(posedge clk);
      #1;
      check("chk_err sticky", {1'b0, chk_err}, 2'b01);
      #3;
      rst_n = 1'b0;
      #1;
      check("chk_err cleared by reset", {1'b0, chk_err}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("chk_err clear after reset", {1'b0, chk_err}, 2'b00);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fa1b
